// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one physical-memory port between I and D cache miss paths
module cache_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  i_grant_count,
    output logic [CNT_W-1:0]  d_grant_count
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 0 = I, 1 = D
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
    logic              d_req;
    logic              grant_d;
    logic              grant_i;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_cnt_d      = i_cnt_q;
        d_cnt_d      = d_cnt_q;
        d_req        = d_read | d_write;
        // On a tie D wins only if I had the previous grant.
        grant_d      = d_req & (~i_read | ~last_grant_q);
        grant_i      = i_read & ~grant_d;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = SERVE_I;
                    addr_d       = i_address;
                    wdata_d      = d_wdata;
                    pmem_read_d  = 1'b1;
                    pmem_write_d = 1'b0;
                    last_grant_d = 1'b0;
                    if (i_cnt_q != {CNT_W{1'b1}}) i_cnt_d = i_cnt_q + CNT_W'(1);
                end else if (grant_d) begin
                    state_d      = SERVE_D;
                    addr_d       = d_address;
                    wdata_d      = d_wdata;
                    pmem_read_d  = ~d_write;
                    pmem_write_d = d_write;
                    last_grant_d = 1'b1;
                    if (d_cnt_q != {CNT_W{1'b1}}) d_cnt_d = d_cnt_q + CNT_W'(1);
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = DONE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_cnt_q      <= '0;
            d_cnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_cnt_q      <= i_cnt_d;
            d_cnt_q      <= d_cnt_d;
        end
    end

    assign pmem_read     = pmem_read_q;
    assign pmem_write    = pmem_write_q;
    assign pmem_address  = addr_q;
    assign pmem_wdata    = wdata_q;
    assign i_resp        = pmem_resp & (state_q == SERVE_I);
    assign d_resp        = pmem_resp & (state_q == SERVE_D);
    assign i_rdata       = pmem_rdata;
    assign d_rdata       = pmem_rdata;
    assign i_grant_count = i_cnt_q;
    assign d_grant_count = d_cnt_q;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares one physical-memory port between the instruction-cache miss path (port a side) and the data-cache miss path (port b side) of the pipelined LC-3b core. Each cache presents a line-sized read or write-back request; the arbiter grants one at a time, drives the physical-memory strobes from latched request fields and routes the single `pmem_resp` back to the winner. Ties are broken round-robin. Two saturating counters record grants per requester for performance runs.

## Interface
Parameters:
- `ADDR_W`, 16: address width (lc3b_word).
- `LINE_W`, 128: cache line width.
- `CNT_W`, 16: grant-counter width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `i_read`  in  1  I-cache line-fill request; level, held until `i_resp`.
- `i_address`  in  ADDR_W  I-cache line address.
- `i_resp`  out  1  I-cache request complete; one-cycle pulse.
- `i_rdata`  out  LINE_W  line returned to the I-cache.
- `d_read`  in  1  D-cache line-fill request; level.
- `d_write`  in  1  D-cache write-back request; level.
- `d_address`  in  ADDR_W  D-cache line address.
- `d_wdata`  in  LINE_W  D-cache write-back line.
- `d_resp`  out  1  D-cache request complete; one-cycle pulse.
- `d_rdata`  out  LINE_W  line returned to the D-cache.
- `pmem_read`  out  1  physical-memory read strobe.
- `pmem_write`  out  1  physical-memory write strobe.
- `pmem_address`  out  ADDR_W  physical-memory address.
- `pmem_wdata`  out  LINE_W  physical-memory write data.
- `pmem_rdata`  in  LINE_W  physical-memory read data; valid with `pmem_resp`.
- `pmem_resp`  in  1  physical-memory completion.
- `i_grant_count`  out  CNT_W  number of I grants since reset, saturating.
- `d_grant_count`  out  CNT_W  number of D grants since reset, saturating.

## Operation
- FSM states:
  - IDLE: no strobes driven. Arbitrates at the rising edge.
    - Only I requesting: go to SERVE_I.
    - Only D requesting (`d_read|d_write`): go to SERVE_D.
    - Both requesting: grant the requester opposite to `last_grant`.
    - Neither requesting: stay in IDLE.
  - On grant, latch the address, latch `d_wdata`, latch the operation (write if `d_write`, else read), set `last_grant`, and increment that requester's counter. Counters stop at all-ones.
  - SERVE_I / SERVE_D: drive `pmem_read` or `pmem_write` plus `pmem_address` and `pmem_wdata` from the latched registers. Hold until `pmem_resp`. On `pmem_resp`, go to DONE.
  - DONE: one turnaround cycle with no strobes, then go to IDLE. This gives the requester the cycle it needs to drop its level request, so no request is double-served.
- `d_read` and `d_write` asserted together: treated as a write-back; `pmem_read` stays 0.
- `i_resp = pmem_resp & (state==SERVE_I)`; `d_resp` is the same with SERVE_D. This path is combinational.
- `i_rdata` and `d_rdata` both equal `pmem_rdata` at all times. Each requester qualifies them with its own resp.
- Request inputs changing mid-service have no effect. The latched fields are used until `pmem_resp`.
- `pmem_resp` outside the SERVE states is ignored.
- `pmem_wdata` is driven from the latched value on reads too. Memory ignores it.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `last_grant`=I (so D wins the first tie). Outputs after reset:
  - `pmem_read`=0, `pmem_write`=0.
  - `pmem_address`=0, `pmem_wdata`=0.
  - `i_resp`=0, `d_resp`=0.
  - Both counters 0.
- Reset mid-service aborts the transaction: strobes drop the next cycle and no resp is issued.
- Latency: request sampled at edge N → strobe asserted in cycle N+1. If memory answers after M cycles of strobe, resp is in cycle N+M. The next grant can be sampled no earlier than edge N+M+2, because of DONE.
- Strobes are stable and registered-state-derived for the whole SERVE state. They deassert in the cycle after `pmem_resp`.
- Back-to-back contention alternates I, D, I, D, …. Each requester waits at most one other transaction.

## Test plan
- Lone I fill: `i_read`=1, `i_address`=0x1230, memory responds after 3 cycles with 0xA5…A5 → `pmem_read`=1 with address 0x1230 for 3 cycles; `i_resp` for one cycle with `i_rdata`=0xA5…A5; `d_resp` never asserts; `i_grant_count`=1.
- Simultaneous first requests after reset: `i_read`=1 and `d_read`=1 (addresses 0x0040 and 0x8000) in the same cycle → D is served first (pmem 0x8000), then DONE, then I (0x0040); counts are 1 and 1.
- Write-back: `d_write`=1, `d_address`=0x2000, `d_wdata`=0xDEAD…BEEF → `pmem_write`=1, `pmem_read`=0, `pmem_wdata` matches; `d_address` is changed to 0x3000 mid-service and `pmem_address` stays 0x2000; one `d_resp`.
- Sustained contention: both requests held high and re-asserted after every resp for 6 transactions → grant order D,I,D,I,D,I; no requester is served twice in a row; no strobe in any DONE cycle.
- Reset mid-service: `rst_n`=0 during SERVE_D with `pmem_resp` never asserted → next cycle all outputs are at reset values, counters are 0, and no `d_resp` is issued.
- Saturation: with `CNT_W`=2, issue 5 I requests → `i_grant_count` sequence 1,2,3,3,3.
